stream_downsize: RTL and testbench
==================================

Name: stream_downsize

Overview:
- Converts a wide stream of T_DATA_RATIO lanes (with per-lane keep and a last flag) into a narrow stream of one lane per transfer.
- Sits directly downstream of the upsize stage and consumes its m_data_o / m_keep_o / m_last_o / m_valid_o / m_ready_i interface unchanged.
- Emits only kept lanes, in ascending lane order, and re-attaches last to the final kept lane.
- Buffers one wide beat and refills it in the same cycle the final lane leaves, so full throughput has no bubble.

Parameters:
- T_DATA_WIDTH, 1, bit width of one lane / of the narrow output.
- T_DATA_RATIO, 2, lanes per wide beat; must be >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- s_data_i  input  T_DATA_WIDTH x [0:T_DATA_RATIO-1]  wide beat, unpacked lane array; lane 0 goes out first.
- s_keep_i  input  T_DATA_RATIO  lane-valid mask; bit i qualifies s_data_i[i].
- s_last_i  input  1  beat ends a packet.
- s_valid_i  input  1  wide beat valid.
- s_ready_o  output  1  block can accept a wide beat this cycle.
- m_data_o  output  T_DATA_WIDTH  current narrow lane.
- m_last_o  output  1  current lane is the final lane of a packet.
- m_valid_o  output  1  m_data_o / m_last_o valid.
- m_ready_i  input  1  downstream accepts.

Behaviour:
- Storage: data buffer [0:T_DATA_RATIO-1], remaining-mask register rem (T_DATA_RATIO bits), last flag register lst.
- Reset (asynchronous) clears rem and lst, and the buffer to 0. Resulting outputs: m_valid_o=0, m_last_o=0, m_data_o=0, s_ready_o=1.
- States:
  - EMPTY when rem==0.
  - SEND when rem!=0.
  - No other state registers.
- Current lane cur = index of the lowest set bit of rem (priority encoder). final = rem has exactly one bit set.
- Outputs are combinational from registers only; there is no combinational path from s_* to m_*:
  - m_valid_o = (rem!=0).
  - m_data_o = buffer[cur] when m_valid_o, else 0.
  - m_last_o = m_valid_o & final & lst.
- out_fire = m_valid_o & m_ready_i. s_ready_o = (rem==0) | (out_fire & final).
- in_fire = s_valid_i & s_ready_o. Register update priority, one per cycle:
  - in_fire: buffer <= s_data_i, rem <= s_keep_i, lst <= s_last_i. This covers a refill in the same cycle the final lane leaves.
  - else out_fire: clear bit cur in rem.
  - else hold.
- Latency: a beat accepted in cycle N presents its first kept lane in cycle N+1.
- Throughput: a beat with k kept lanes occupies the output for exactly k cycles. Back-to-back beats give one narrow transfer per cycle.
- Lane order is ascending index. Lanes with keep=0 are skipped with no idle cycle, so keep need not be contiguous.
- keep==0 beat:
  - Accepted and discarded; rem stays 0, nothing is output.
  - If it carries last, the last is dropped. This is a protocol error from upstream and gets no special handling.
- Backpressure: while m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o are held stable. s_ready_o=0 unless the block is empty.
- m_valid_o never drops without a transfer except on reset.
- Reset mid-beat: pending lanes are discarded and m_valid_o falls asynchronously with rst_n.
- Input stability is not required after acceptance: the beat is captured at in_fire.

Test Plan:
- WIDTH=8, RATIO=4; one beat data {0x10,0x11,0x12,0x13}, keep=4'b1111, last=1; m_ready=1 -> 0x10,0x11,0x12,0x13 on 4 consecutive cycles starting the cycle after accept. m_last=1 only with 0x13. s_ready=0 during the first three outputs and 1 during the fourth.
- Two beats offered back-to-back, {0xA0..0xA3} last=0 then {0xB0..0xB3} last=1, keep all ones -> 8 outputs in 8 consecutive cycles with no gap. The second beat is accepted in the 0xA3 cycle. m_last=1 only on 0xB3.
- Partial keep=4'b0011, data {0x01,0x02,0x03,0x04}, last=1 -> outputs 0x01, then 0x02 with m_last=1. s_ready returns high in the 0x02 cycle.
- Sparse keep=4'b1010, data {0x21,0x22,0x23,0x24}, last=0 -> outputs 0x22 then 0x24, m_last=0 both. Then keep=4'b0000 last=1 -> accepted, no output, s_ready=1 on the next cycle.
- Backpressure: keep=4'b1111, m_ready=0 for 3 cycles after the first valid -> m_data=lane0 and m_valid=1 held stable for 3 cycles, s_ready=0. Then m_ready=1 -> the remaining lanes follow in order.
- Reset mid-beat: assert rst_n=0 after 2 of 4 lanes sent -> m_valid=0 and s_ready=1 immediately. After release, no remaining lanes appear, and a new beat is processed normally.

Source files
------------

// File: rtl/stream_downsize.sv
// stream_downsize: wide-to-narrow stream converter.
//   Accepts one wide beat of T_DATA_RATIO lanes (per-lane keep, packet last)
//   and replays its kept lanes one per transfer, lowest lane first. The
//   packet last is re-attached to the final kept lane. A new beat can be
//   captured in the same cycle the final lane leaves, so back-to-back beats
//   stream with no bubble.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   s_data_i[0:R-1]       wide beat, lane 0 leaves first
//   s_keep_i              lane-valid mask
//   s_last_i              beat closes a packet
//   s_valid_i/s_ready_o   wide handshake
//   m_data_o, m_last_o    current narrow lane, last-of-packet flag
//   m_valid_o/m_ready_i   narrow handshake

// One lane slot of the wide-beat buffer.
module stream_downsize_lane #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
endmodule

module stream_downsize #(
  parameter int T_DATA_WIDTH = 1,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [0:T_DATA_RATIO-1],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);
  localparam int W     = T_DATA_WIDTH;
  localparam int R     = T_DATA_RATIO;
  localparam int IDX_W = $clog2(R);

  logic [W-1:0]     data_q [0:R-1];
  logic [R-1:0]     rem;     // lanes of the held beat still to send
  logic             lst;
  logic [R-1:0]     rem_dn;  // rem with its lowest set bit cleared
  logic [IDX_W-1:0] cur;
  logic             is_final, out_fire, in_fire;

  // Lowest set bit of rem wins; scanning downward leaves it last.
  always_comb begin
    cur = '0;
    for (int i = R-1; i >= 0; i--)
      if (rem[i]) cur = IDX_W'(i);
  end

  assign rem_dn    = rem & (rem - R'(1));
  assign is_final  = (rem != '0) && (rem_dn == '0);
  assign m_valid_o = (rem != '0);
  assign m_data_o  = m_valid_o ? data_q[cur] : '0;
  assign m_last_o  = m_valid_o & is_final & lst;
  assign out_fire  = m_valid_o & m_ready_i;
  assign s_ready_o = (rem == '0) | (out_fire & is_final);
  assign in_fire   = s_valid_i & s_ready_o;

  for (genvar g = 0; g < R; g++) begin : g_lane
    stream_downsize_lane #(.W(W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (in_fire),
      .d    (s_data_i[g]),
      .q    (data_q[g])
    );
  end

  // A refill takes priority over retiring the final lane: both happen in
  // the same cycle and the new mask simply replaces the old one.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      lst <= 1'b0;
    end else if (in_fire) begin
      rem <= s_keep_i;
      lst <= s_last_i;
    end else if (out_fire) begin
      rem <= rem_dn;
    end
endmodule

// File: tb/tb_stream_downsize.sv
module tb_stream_downsize;
  localparam int W = 8;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] s_data [0:R-1];
  logic [R-1:0] s_keep = '0;
  logic         s_last = 1'b0, s_valid = 1'b0, s_ready;
  logic [W-1:0] m_data;
  logic         m_last, m_valid, m_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data_i (s_data),
    .s_keep_i (s_keep),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready)
  );

  // One row = inputs held for one cycle + outputs expected in that cycle.
  typedef struct {
    logic [R-1:0][W-1:0] d;  // d[0] is lane 0
    logic [R-1:0]        keep;
    logic                last, valid, mr;
    logic                sr, mv;
    logic [W-1:0]        md;
    logic                ml;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] d, input logic [3:0] keep,
                     input logic last, valid, mr,
                     input logic sr, mv, input logic [7:0] md, input logic ml);
    vec_t v;
    v.d = d; v.keep = keep; v.last = last; v.valid = valid; v.mr = mr;
    v.sr = sr; v.mv = mv; v.md = md; v.ml = ml;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int tag, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d got %h want %h", name, tag, act, exp);
    end
  endtask

  task automatic chk_out(input int tag, input logic sr, mv, input logic [7:0] md, input logic ml);
    chk("s_ready", tag, 32'(s_ready), 32'(sr));
    chk("m_valid", tag, 32'(m_valid), 32'(mv));
    chk("m_data",  tag, 32'(m_data),  32'(md));
    chk("m_last",  tag, 32'(m_last),  32'(ml));
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] keep,
                       input logic last, valid, mr);
    logic [R-1:0][W-1:0] dd;
    dd = d;
    for (int i = 0; i < R; i++) s_data[i] = dd[i];
    s_keep = keep; s_last = last; s_valid = valid; m_ready = mr;
  endtask

  initial begin
    drive(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // full beat, last=1
    add(32'h0,        4'h0, 0, 0, 1,  1, 0, 8'h00, 0);
    add(32'h13121110, 4'hF, 1, 1, 1,  1, 0, 8'h00, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'h10, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'h11, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'h12, 0);
    add(32'h0,        4'h0, 0, 0, 1,  1, 1, 8'h13, 1);
    // back-to-back beats, B waits and is taken on the A3 cycle
    add(32'hA3A2A1A0, 4'hF, 0, 1, 1,  1, 0, 8'h00, 0);
    add(32'hB3B2B1B0, 4'hF, 1, 1, 1,  0, 1, 8'hA0, 0);
    add(32'hB3B2B1B0, 4'hF, 1, 1, 1,  0, 1, 8'hA1, 0);
    add(32'hB3B2B1B0, 4'hF, 1, 1, 1,  0, 1, 8'hA2, 0);
    add(32'hB3B2B1B0, 4'hF, 1, 1, 1,  1, 1, 8'hA3, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'hB0, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'hB1, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'hB2, 0);
    add(32'h0,        4'h0, 0, 0, 1,  1, 1, 8'hB3, 1);
    // partial keep 0011
    add(32'h04030201, 4'h3, 1, 1, 1,  1, 0, 8'h00, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'h01, 0);
    add(32'h0,        4'h0, 0, 0, 1,  1, 1, 8'h02, 1);
    // sparse keep 1010, last=0, then empty keep with last
    add(32'h24232221, 4'hA, 0, 1, 1,  1, 0, 8'h00, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'h22, 0);
    add(32'h0,        4'h0, 0, 0, 1,  1, 1, 8'h24, 0);
    add(32'h55555555, 4'h0, 1, 1, 1,  1, 0, 8'h00, 0);
    add(32'h0,        4'h0, 0, 0, 1,  1, 0, 8'h00, 0);
    // backpressure on lane 0 for 3 cycles, an offered beat is refused
    add(32'h34333231, 4'hF, 1, 1, 1,  1, 0, 8'h00, 0);
    add(32'h0,        4'h0, 0, 0, 0,  0, 1, 8'h31, 0);
    add(32'h99999999, 4'hF, 0, 1, 0,  0, 1, 8'h31, 0);
    add(32'h0,        4'h0, 0, 0, 0,  0, 1, 8'h31, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'h31, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'h32, 0);
    add(32'h0,        4'h0, 0, 0, 1,  0, 1, 8'h33, 0);
    add(32'h0,        4'h0, 0, 0, 1,  1, 1, 8'h34, 1);
    // single top lane, stalled while final
    add(32'h64636261, 4'h8, 1, 1, 1,  1, 0, 8'h00, 0);
    add(32'h0,        4'h0, 0, 0, 0,  0, 1, 8'h64, 1);
    add(32'h0,        4'h0, 0, 0, 1,  1, 1, 8'h64, 1);
    add(32'h0,        4'h0, 0, 0, 1,  1, 0, 8'h00, 0);

    // reset state, checked while reset is held
    repeat (2) @(negedge clk);
    #1 chk_out(-1, 1, 0, 8'h00, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].d, tbl[i].keep, tbl[i].last, tbl[i].valid, tbl[i].mr);
      #1 chk_out(i, tbl[i].sr, tbl[i].mv, tbl[i].md, tbl[i].ml);
    end

    // reset mid-beat: two lanes out, then reset drops the rest
    @(negedge clk);
    drive(32'h44434241, 4'hF, 1'b1, 1'b1, 1'b1);
    #1 chk_out(100, 1, 0, 8'h00, 0);
    @(negedge clk);
    drive(32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    #1 chk_out(101, 0, 1, 8'h41, 0);
    @(negedge clk);
    #1 chk_out(102, 0, 1, 8'h42, 0);
    @(negedge clk);
    #1 chk_out(103, 0, 1, 8'h43, 0);
    rst_n = 1'b0;
    #1 chk_out(104, 1, 0, 8'h00, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_out(105, 1, 0, 8'h00, 0);
    @(negedge clk);
    #1 chk_out(106, 1, 0, 8'h00, 0);
    // new beat after reset, keep 0101
    @(negedge clk);
    drive(32'h54535251, 4'h5, 1'b1, 1'b1, 1'b1);
    #1 chk_out(107, 1, 0, 8'h00, 0);
    @(negedge clk);
    drive(32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    #1 chk_out(108, 0, 1, 8'h51, 0);
    @(negedge clk);
    #1 chk_out(109, 1, 1, 8'h53, 1);
    @(negedge clk);
    #1 chk_out(110, 1, 0, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
